uart_tx_fifo: RTL

UART transmitter that drains the transmit-side FIFO and serialises each word onto the line. It sits directly downstream of the asynchronous FIFO, in that FIFO's read-clock domain. It pops a word whenever the FIFO is non-empty and the transmitter is idle, then emits a standard start/data/stop frame, LSB first.

---
 rtl/uart_tx_fifo.sv | 121 ++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a first-word-fall-through FIFO: pops one word when idle
// and sends it as a start / data (LSB first) / stop frame on a glitch-free registered line.
module uart_tx_fifo #(
  parameter int word_width   = 8,
  parameter int clks_per_bit = 868,
  parameter int stop_bits    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [word_width-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  rd,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);
  localparam int TICK_W = $clog2(clks_per_bit);
  localparam int IDX_W  = $clog2(word_width) + 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(clks_per_bit - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(word_width - 1);
  localparam logic              STOP_LAST = (stop_bits == 2);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [TICK_W-1:0]     tick_q, tick_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  stop_q, stop_d;
  logic [word_width-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  bit_end;

  assign bit_end = (tick_q == TICK_LAST);
  assign rd      = (state_q == IDLE) & ~fifo_empty & ~reset;

  // tx_d is chosen one cycle ahead so the line itself comes straight from a flop
  always_comb begin
    state_d = state_q;
    tick_d  = bit_end ? '0 : tick_q + 1'b1;
    idx_d   = idx_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        tick_d = '0;
        if (rd) begin
          state_d = START;
          shift_d = fifo_data;
          idx_d   = '0;
          stop_d  = 1'b0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d = shift_d[0];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop_q == STOP_LAST) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            stop_d = ~stop_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_done = done_q;
endmodule
